ddr3_arbiter: RTL and testbench
===============================

# ddr3_arbiter

Two-port round-robin arbiter that shares the single 32-bit DDR3 front-end request port (25-bit word address, byte enables, read/write request, read-data return) between two requesters. It forwards each granted command with zero added latency and records the issuing port of every accepted read in an in-order return-ID FIFO, so returned read data is routed back to the correct requester. It sits between the CPU/DMA-side masters and the DDR3 interface block.

## Interface
Parameters:
- ID_DEPTH_BITS, 4: log2 of return-ID FIFO depth (default 16 outstanding reads).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pN_ready  out  1  port N (N=0,1) command accepted this cycle if asserted together with a request.
- pN_addr  in  25  port N word address.
- pN_write_data  in  32  port N write data.
- pN_byte_enable  in  4  port N write byte enables.
- pN_write_req  in  1  port N write request.
- pN_read_req  in  1  port N read request (never together with pN_write_req).
- pN_read_data  out  32  port N returned read data.
- pN_read_data_valid  out  1  port N read data valid strobe.
- mem_ready  in  1  downstream can accept a command.
- mem_addr  out  25  forwarded address.
- mem_write_data  out  32  forwarded write data.
- mem_byte_enable  out  4  forwarded byte enables.
- mem_write_req  out  1  forwarded write request.
- mem_read_req  out  1  forwarded read request.
- mem_read_data  in  32  downstream read data.
- mem_read_data_valid  in  1  downstream read data strobe.
- return_error  out  1  sticky: read data returned with no outstanding read recorded.

## Operation
- Port N requesting = pN_write_req | pN_read_req, masked to pN_write_req alone when the ID FIFO is full.
- Grant: single requester wins; both requesting → the port ≠ last_grant wins. Combinational from requests and last_grant register.
- Granted port's addr/data/be/reqs drive mem_*; no grant → mem_write_req = mem_read_req = 0, other mem_* outputs = port 0 values.
- pN_ready = granted(N) & mem_ready & (not a read, or FIFO not full). Non-granted port sees ready 0.
- Accept = granted request & pN_ready. On accept: last_grant ← N; if read, push N into ID FIFO.
- Requester holds its command stable until ready; arbiter does not latch commands.
- Return: on mem_read_data_valid, pop FIFO head H; pH_read_data_valid = 1, both pN_read_data = mem_read_data (unconditionally).
- mem_read_data_valid with FIFO empty: nothing popped, no port strobed, return_error set until reset.

## Timing
- Reset values: last_grant = 1 (port 0 wins first contention), FIFO count = 0, return_error = 0, all pN_ready/pN_read_data_valid/mem_*_req = 0 while reset asserted.
- Command path: 0 cycles, combinational. Return path: 0 cycles, combinational from FIFO head.
- FIFO holds 2^ID_DEPTH_BITS entries. Full: reads stalled, writes still granted. Simultaneous push and pop: count unchanged, allowed even when full (pop frees the slot first).
- Pointers wrap modulo depth. Count is ID_DEPTH_BITS+1 wide.
- Reset asserted mid-operation: FIFO cleared immediately. Subsequent stale returns set return_error.

## Configuration
- DDR3_ARBITER_PERF_COUNTERS_EN: when defined, adds outputs p0_grant_count, p1_grant_count, stall_count (32 bits each, reset 0, wrapping). They count accepts per port and cycles with any request and no accept. When undefined, these ports and registers are absent.

## Test plan
- Port 0 only, write addr 0x0000010, data 0xDEADBEEF, be 0xF, mem_ready 1 → same-cycle mem_write_req, mem_addr 0x0000010, p0_ready 1.
- Both ports hold reads for 4 cycles, mem_ready 1 → grant order p0,p1,p0,p1. Returns 0x11,0x22,0x33,0x44 strobe p0,p1,p0,p1 valid respectively.
- Port 1 issues 16 reads with no returns → 17th read stalled (p1_ready 0), p0 write still accepted. One return in the same cycle as the next read → that read accepted, count stays 16.
- mem_ready 0 with both requesting → no accept, last_grant unchanged. mem_ready 1 next cycle → the previously entitled port is granted.
- mem_read_data_valid with empty FIFO → no pN_read_data_valid, return_error 1 held. reset → return_error 0.
- Reset asserted with 3 reads outstanding → after release, FIFO count 0, first grant under contention goes to port 0.

Source files
------------

// File: rtl/ddr3_arbiter.sv
// ddr3_arbiter: two-port round-robin arbiter in front of the DDR3 command port.
// Commands are forwarded combinationally; an in-order return-ID FIFO records
// which port issued each accepted read so read data is strobed back to it.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   pN_addr/write_data/...  port N (N=0,1) command inputs
//   pN_ready                port N command accepted this cycle
//   pN_read_data(_valid)    port N read data return
//   mem_*                   downstream command port and read data return
//   return_error            sticky: read data arrived with nothing outstanding
//
// Optional: define DDR3_ARBITER_PERF_COUNTERS_EN to add p0_grant_count,
// p1_grant_count and stall_count outputs.
module ddr3_arbiter #(
    parameter int ID_DEPTH_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        p0_ready,
    input  logic [24:0] p0_addr,
    input  logic [31:0] p0_write_data,
    input  logic [3:0]  p0_byte_enable,
    input  logic        p0_write_req,
    input  logic        p0_read_req,
    output logic [31:0] p0_read_data,
    output logic        p0_read_data_valid,
    output logic        p1_ready,
    input  logic [24:0] p1_addr,
    input  logic [31:0] p1_write_data,
    input  logic [3:0]  p1_byte_enable,
    input  logic        p1_write_req,
    input  logic        p1_read_req,
    output logic [31:0] p1_read_data,
    output logic        p1_read_data_valid,
    input  logic        mem_ready,
    output logic [24:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write_req,
    output logic        mem_read_req,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_data_valid,
`ifdef DDR3_ARBITER_PERF_COUNTERS_EN
    output logic [31:0] p0_grant_count,
    output logic [31:0] p1_grant_count,
    output logic [31:0] stall_count,
`endif
    output logic        return_error
);

    localparam int DEPTH = 1 << ID_DEPTH_BITS;
    localparam int CW    = ID_DEPTH_BITS + 1;

    logic                     last_grant_q, last_grant_d;
    logic [DEPTH-1:0]         id_q, id_d;
    logic [ID_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ID_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     return_error_q, return_error_d;

    logic fifo_empty;
    logic pop;
    logic full_blk;
    logic p0_req;
    logic p1_req;
    logic grant0;
    logic grant1;
    logic accept;
    logic push;
    logic head;

    assign fifo_empty = (count_q == '0);
    assign pop        = mem_read_data_valid & ~fifo_empty & ~reset;
    // A same-cycle pop frees a slot, so a full FIFO only blocks reads
    // when no return is arriving.
    assign full_blk   = (count_q == CW'(DEPTH)) & ~pop;

    assign p0_req = p0_write_req | (p0_read_req & ~full_blk);
    assign p1_req = p1_write_req | (p1_read_req & ~full_blk);

    // Contention goes to the port that did not win last.
    assign grant0 = ~reset & p0_req & (~p1_req | last_grant_q);
    assign grant1 = ~reset & p1_req & ~grant0;

    always_comb begin
        mem_addr        = p0_addr;
        mem_write_data  = p0_write_data;
        mem_byte_enable = p0_byte_enable;
        mem_write_req   = 1'b0;
        mem_read_req    = 1'b0;
        if (grant1) begin
            mem_addr        = p1_addr;
            mem_write_data  = p1_write_data;
            mem_byte_enable = p1_byte_enable;
            mem_write_req   = p1_write_req;
            mem_read_req    = p1_read_req;
        end else if (grant0) begin
            mem_write_req = p0_write_req;
            mem_read_req  = p0_read_req;
        end
    end

    assign p0_ready = grant0 & mem_ready;
    assign p1_ready = grant1 & mem_ready;
    assign accept   = p0_ready | p1_ready;
    assign push     = accept & mem_read_req;

    assign head               = id_q[rd_ptr_q];
    assign p0_read_data       = mem_read_data;
    assign p1_read_data       = mem_read_data;
    assign p0_read_data_valid = pop & ~head;
    assign p1_read_data_valid = pop & head;
    assign return_error       = return_error_q;

    always_comb begin
        last_grant_d   = last_grant_q;
        id_d           = id_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        return_error_d = return_error_q;
        if (accept) begin
            last_grant_d = p1_ready;
        end
        if (push) begin
            id_d[wr_ptr_q] = p1_ready;
            wr_ptr_d       = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (mem_read_data_valid & fifo_empty) begin
            return_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q   <= 1'b1;
            id_q           <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            return_error_q <= 1'b0;
        end else begin
            last_grant_q   <= last_grant_d;
            id_q           <= id_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            return_error_q <= return_error_d;
        end
    end

`ifdef DDR3_ARBITER_PERF_COUNTERS_EN
    logic [31:0] p0_grant_count_q, p0_grant_count_d;
    logic [31:0] p1_grant_count_q, p1_grant_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        any_req;

    assign any_req = p0_write_req | p0_read_req | p1_write_req | p1_read_req;

    always_comb begin
        p0_grant_count_d = p0_grant_count_q;
        p1_grant_count_d = p1_grant_count_q;
        stall_count_d    = stall_count_q;
        if (p0_ready) begin
            p0_grant_count_d = p0_grant_count_q + 32'd1;
        end
        if (p1_ready) begin
            p1_grant_count_d = p1_grant_count_q + 32'd1;
        end
        if (any_req & ~accept) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_grant_count_q <= '0;
            p1_grant_count_q <= '0;
            stall_count_q    <= '0;
        end else begin
            p0_grant_count_q <= p0_grant_count_d;
            p1_grant_count_q <= p1_grant_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign p0_grant_count = p0_grant_count_q;
    assign p1_grant_count = p1_grant_count_q;
    assign stall_count    = stall_count_q;
`endif

endmodule

// File: tb/tb_ddr3_arbiter.sv
// tb_ddr3_arbiter: directed self-checking bench for ddr3_arbiter.
// Inputs change 1 time unit after the rising edge; outputs checked 2 units later.
module tb_ddr3_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_ready, p1_ready;
    logic [24:0] p0_addr, p1_addr;
    logic [31:0] p0_write_data, p1_write_data;
    logic [3:0]  p0_byte_enable, p1_byte_enable;
    logic        p0_write_req, p1_write_req;
    logic        p0_read_req, p1_read_req;
    logic [31:0] p0_read_data, p1_read_data;
    logic        p0_read_data_valid, p1_read_data_valid;
    logic        mem_ready;
    logic [24:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_req, mem_read_req;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;
    logic        return_error;
`ifdef DDR3_ARBITER_PERF_COUNTERS_EN
    logic [31:0] p0_grant_count, p1_grant_count, stall_count;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    ddr3_arbiter #(.ID_DEPTH_BITS(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .p0_ready           (p0_ready),
        .p0_addr            (p0_addr),
        .p0_write_data      (p0_write_data),
        .p0_byte_enable     (p0_byte_enable),
        .p0_write_req       (p0_write_req),
        .p0_read_req        (p0_read_req),
        .p0_read_data       (p0_read_data),
        .p0_read_data_valid (p0_read_data_valid),
        .p1_ready           (p1_ready),
        .p1_addr            (p1_addr),
        .p1_write_data      (p1_write_data),
        .p1_byte_enable     (p1_byte_enable),
        .p1_write_req       (p1_write_req),
        .p1_read_req        (p1_read_req),
        .p1_read_data       (p1_read_data),
        .p1_read_data_valid (p1_read_data_valid),
        .mem_ready          (mem_ready),
        .mem_addr           (mem_addr),
        .mem_write_data     (mem_write_data),
        .mem_byte_enable    (mem_byte_enable),
        .mem_write_req      (mem_write_req),
        .mem_read_req       (mem_read_req),
        .mem_read_data      (mem_read_data),
        .mem_read_data_valid(mem_read_data_valid),
`ifdef DDR3_ARBITER_PERF_COUNTERS_EN
        .p0_grant_count     (p0_grant_count),
        .p1_grant_count     (p1_grant_count),
        .stall_count        (stall_count),
`endif
        .return_error       (return_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        p0_write_req        = 1'b0;
        p0_read_req         = 1'b0;
        p1_write_req        = 1'b0;
        p1_read_req         = 1'b0;
        mem_read_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        p0_addr             = 25'h0000010;
        p0_write_data       = 32'hDEADBEEF;
        p0_byte_enable      = 4'hF;
        p1_addr             = 25'h0000020;
        p1_write_data       = 32'hCAFEF00D;
        p1_byte_enable      = 4'h3;
        mem_read_data       = 32'h0;
        mem_ready           = 1'b1;
        idle_inputs();
        p0_write_req        = 1'b1;
        tick();
        settle();
        chk("rst_p0_ready", {31'b0, p0_ready}, 32'd0);
        chk("rst_mem_wr", {31'b0, mem_write_req}, 32'd0);
        chk("rst_err", {31'b0, return_error}, 32'd0);

        // Single port write, forwarded with zero latency.
        tick();
        reset = 1'b0;
        settle();
        chk("wr_mem_wr", {31'b0, mem_write_req}, 32'd1);
        chk("wr_mem_rd", {31'b0, mem_read_req}, 32'd0);
        chk("wr_addr", {7'b0, mem_addr}, 32'h10);
        chk("wr_data", mem_write_data, 32'hDEADBEEF);
        chk("wr_be", {28'b0, mem_byte_enable}, 32'hF);
        chk("wr_p0_ready", {31'b0, p0_ready}, 32'd1);
        chk("wr_p1_ready", {31'b0, p1_ready}, 32'd0);
        tick();
        idle_inputs();

        // Alternating reads under contention, then in-order returns.
        do_reset();
        p0_addr     = 25'h00000A0;
        p1_addr     = 25'h00000A1;
        p0_read_req = 1'b1;
        p1_read_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_p0_ready", {31'b0, p0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_p1_ready", {31'b0, p1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_addr", {7'b0, mem_addr}, (i % 2 == 0) ? 32'hA0 : 32'hA1);
            chk("rr_mem_rd", {31'b0, mem_read_req}, 32'd1);
            tick();
        end
        idle_inputs();
        mem_read_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_read_data = 32'h11 * (i + 1);
            settle();
            chk("ret_p0_v", {31'b0, p0_read_data_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("ret_p1_v", {31'b0, p1_read_data_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("ret_p0_d", p0_read_data, 32'h11 * (i + 1));
            chk("ret_p1_d", p1_read_data, 32'h11 * (i + 1));
            tick();
        end
        mem_read_data_valid = 1'b0;
        settle();
        chk("ret_no_err", {31'b0, return_error}, 32'd0);
        tick();

        // mem_ready low: no accept, entitlement kept (last grant was p1).
        mem_ready    = 1'b0;
        p0_write_req = 1'b1;
        p1_write_req = 1'b1;
        settle();
        chk("mr0_p0_ready", {31'b0, p0_ready}, 32'd0);
        chk("mr0_p1_ready", {31'b0, p1_ready}, 32'd0);
        chk("mr0_addr", {7'b0, mem_addr}, 32'hA0);
        tick();
        mem_ready = 1'b1;
        settle();
        chk("mr1_p0_ready", {31'b0, p0_ready}, 32'd1);
        chk("mr1_p1_ready", {31'b0, p1_ready}, 32'd0);
        tick();
        idle_inputs();

        // Fill the return-ID FIFO from port 1.
        p1_read_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("fill_p1_ready", {31'b0, p1_ready}, 32'd1);
            tick();
        end
        settle();
        chk("full_p1_ready", {31'b0, p1_ready}, 32'd0);
        chk("full_mem_rd", {31'b0, mem_read_req}, 32'd0);
        p0_write_req = 1'b1;
        settle();
        chk("full_p0_wr_ready", {31'b0, p0_ready}, 32'd1);
        chk("full_p0_mem_wr", {31'b0, mem_write_req}, 32'd1);
        chk("full_p1_blocked", {31'b0, p1_ready}, 32'd0);
        tick();
        p0_write_req        = 1'b0;
        mem_read_data       = 32'h55;
        mem_read_data_valid = 1'b1;
        settle();
        chk("pp_p1_ready", {31'b0, p1_ready}, 32'd1);
        chk("pp_mem_rd", {31'b0, mem_read_req}, 32'd1);
        chk("pp_p1_v", {31'b0, p1_read_data_valid}, 32'd1);
        tick();
        mem_read_data_valid = 1'b0;
        settle();
        chk("pp_still_full", {31'b0, p1_ready}, 32'd0);
        tick();
        idle_inputs();

        // Stray return with empty FIFO.
        do_reset();
        mem_read_data_valid = 1'b1;
        settle();
        chk("stray_p0_v", {31'b0, p0_read_data_valid}, 32'd0);
        chk("stray_p1_v", {31'b0, p1_read_data_valid}, 32'd0);
        tick();
        mem_read_data_valid = 1'b0;
        tick();
        settle();
        chk("stray_err_held", {31'b0, return_error}, 32'd1);
        do_reset();
        settle();
        chk("stray_err_clr", {31'b0, return_error}, 32'd0);

        // Reset with three reads outstanding.
        p0_read_req = 1'b1;
        p1_read_req = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_p0_ready", {31'b0, p0_ready}, 32'd0);
        chk("mid_rst_mem_rd", {31'b0, mem_read_req}, 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        mem_read_data_valid = 1'b1;
        settle();
        chk("stale_p0_v", {31'b0, p0_read_data_valid}, 32'd0);
        chk("stale_p1_v", {31'b0, p1_read_data_valid}, 32'd0);
        tick();
        mem_read_data_valid = 1'b0;
        settle();
        chk("stale_err", {31'b0, return_error}, 32'd1);
        p0_read_req = 1'b1;
        p1_read_req = 1'b1;
        settle();
        chk("post_rst_p0", {31'b0, p0_ready}, 32'd1);
        chk("post_rst_p1", {31'b0, p1_ready}, 32'd0);
        tick();
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
